// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t    - controller FSM states (IDLE, CALC, DONE)
//   digit_t    - decoded Booth digit selecting 0, +-M or +-2M
//   booth_ndig - number of radix-4 digits needed for a WIDTH-bit multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    NEG1,
    POS2,
    NEG2
  } digit_t;

  // The multiplier is extended by two bits so an unsigned top bit still has a
  // non-negative final digit; that costs one digit beyond WIDTH/2.
  function automatic int unsigned booth_ndig(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: combinational radix-4 Booth partial-product generator.
//   grp          - Booth group {y[2i+1], y[2i], y[2i-1]}
//   multiplicand - WIDTH-bit multiplicand
//   tc_mode      - 1: multiplicand is two's complement, 0: unsigned
//   pp           - 2*WIDTH-bit partial product (0, +-M, +-2M), not yet shifted
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]         grp,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               tc_mode,
  output logic [2*WIDTH-1:0] pp
);

  digit_t             sel;
  logic [2*WIDTH-1:0] mext;

  always_comb begin
    mext = {{WIDTH{tc_mode & multiplicand[WIDTH-1]}}, multiplicand};

    unique case (grp)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase

    // Negation is modulo 2^(2*WIDTH), which is all the accumulator needs.
    case (sel)
      POS1:    pp = mext;
      NEG1:    pp = -mext;
      POS2:    pp = mext << 1;
      NEG2:    pp = -(mext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one digit per cycle.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready high only when idle)
//   multiplicand         - WIDTH-bit operand, multiplier - WIDTH-bit operand
//   tc_mode              - 1: two's-complement operands, 0: unsigned (sampled at accept)
//   out_valid / out_ready- product handshake (product held until taken)
//   product              - 2*WIDTH-bit result
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as all remaining
// Booth digits are zero; the product value is the same either way.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               tc_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned NDIG = booth_ndig(WIDTH);
  localparam int unsigned IW   = $clog2(NDIG);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic               tc;
  // Extended multiplier with the implicit zero below the LSB at bit 0:
  // yx[k+1] holds y[k], so digit i reads yx[2i+2:2i].
  logic [WIDTH+2:0]   yx;
  logic [IW-1:0]      idx;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] pp;
  logic [2:0]         grp;
  logic               last;
`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:0]     yhi;
`endif

  booth_pp_gen #(
    .WIDTH(WIDTH)
  ) u_pp_gen (
    .grp         (grp),
    .multiplicand(mcand),
    .tc_mode     (tc),
    .pp          (pp)
  );

  always_comb begin
    grp     = 3'(yx >> {idx, 1'b0});
    acc_nxt = acc + (pp << {idx, 1'b0});
    last    = (idx == IW'(NDIG - 1));
`ifdef BOOTH_EARLY_TERM_EN
    // y[WIDTH+1:2i+1] with sign fill; uniform bits mean every later digit is 0.
    yhi  = $unsigned($signed(yx[WIDTH+2:2]) >>> {idx, 1'b0});
    last = last | (yhi == '0) | (yhi == '1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      idx       <= '0;
      mcand     <= '0;
      tc        <= 1'b0;
      yx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= multiplicand;
            tc       <= tc_mode;
            yx       <= {{2{tc_mode & multiplier[WIDTH-1]}}, multiplier, 1'b0};
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (last) begin
            product   <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
`timescale 1ns/1ps
module tb_booth_r4_seq_mult;

  localparam int W    = 8;
  localparam int NDIG = W / 2 + 1;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           tc_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rdy_rand = 1'b0;
  bit seen     = 1'b0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_q[$];

  booth_r4_seq_mult #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .tc_mode     (tc_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 7) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Reference: exact product by plain integer arithmetic, kept modulo 2^(2W).
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic t);
    longint av = t ? longint'($signed(a)) : longint'({1'b0, a});
    longint bv = t ? longint'($signed(b)) : longint'({1'b0, b});
    return (2*W)'(av * bv);
  endfunction

  // Cycles from accept to out_valid: NDIG, or with early termination the first
  // digit after which the multiplier value has nothing left above it.
  function automatic int ref_latency(input logic [W-1:0] b, input logic t);
    longint bv = t ? longint'($signed(b)) : longint'({1'b0, b});
    if (EARLY_TERM) begin
      for (int i = 0; i < NDIG; i++) begin
        if ((bv >>> (2 * i + 1)) == 0 || (bv >>> (2 * i + 1)) == -1) return i + 1;
      end
    end
    return NDIG;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic t);
    int guard = 0;
    multiplicand = a;
    multiplier   = b;
    tc_mode      = t;
    in_valid     = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(ref_product(a, b, t));
    lat_q.push_back(ref_latency(b, t));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    tc_mode      = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d products outstanding, expected 0", exp_q.size());
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard front.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        if (!seen) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: product=0x%0h presented, expected no output", product);
          seen = 1'b1;
        end
        if (out_ready) seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
        end
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          check("product", 32'(product), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int g;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed corner operands
    issue(8'h80, 8'h80, 1'b1);
    drain();
    issue(8'hFF, 8'hFF, 1'b0);
    issue(8'hFF, 8'h7F, 1'b1);
    drain();
    issue(8'd100, 8'd1, 1'b0);
    issue(8'd100, 8'h80, 1'b0);
    drain();

    // Backpressure: product held, new operands ignored
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0);
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    in_valid     = 1'b1;
    multiplicand = 8'hAA;
    multiplier   = 8'h55;
    tc_mode      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_product_stable", 32'(product), 32'(ref_product(8'h12, 8'h34, 1'b0)));
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Reset two cycles into CALC: nothing delivered
    multiplicand = 8'h55;
    multiplier   = 8'h66;
    tc_mode      = 1'b0;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_accepted", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    issue(8'd3, 8'd5, 1'b0);
    drain();

    // Random operands, modes and handshake delays
    rdy_rand = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
